regfile_writeback: RTL and testbench

Writeback controller that drives the CPU register file's single write port. It merges two writeback sources into one registered write per cycle: single-cycle ALU results and in-order load responses. It also tracks outstanding loads in a destination-tag FIFO and exports a per-register busy scoreboard for the issue stage's hazard checks. It sits between the execute/memory stages and the register file's `wr_ena`/`wr_addr`/`wr_data` inputs.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/regfile_writeback_pkg.sv | 15 +
 rtl/regfile_writeback_if.sv | 32 +++
 rtl/regfile_writeback_tag_fifo.sv | 69 ++++++
 rtl/register.sv | 27 ++
 rtl/regfile_writeback.sv | 151 +++++++++++++++
 tb/tb_regfile_writeback.sv | 232 +++++++++++++++++++++++
 7 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types used across the register-file write path.
//   reg_addr_t : architectural register index (x0..x31)
//   word_t     : 32-bit data word
//   REG_ZERO   : hard-wired zero register index
package cpu_pkg;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_writeback_pkg.sv
// Local types/helpers for the writeback controller.
//   hold_state_t : state of the single load-data hold slot
//   tag_onehot() : one-hot 32-bit decode of a register index
package regfile_writeback_pkg;
  import cpu_pkg::*;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  function automatic word_t tag_onehot(input reg_addr_t tag);
    return word_t'(32'd1) << tag;
  endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// Bus bundle between execute/memory stages, the writeback controller and the
// register file write port.
//   slave  : the writeback controller's view
//   master : the surrounding pipeline's view (drives ALU/load inputs)
interface regfile_writeback_if;
  import cpu_pkg::*;

  logic      alu_valid;
  reg_addr_t alu_rd;
  word_t     alu_data;
  logic      ld_issue;
  reg_addr_t ld_issue_rd;
  logic      ld_issue_ready;
  logic      ld_valid;
  word_t     ld_data;
  logic      ld_ready;
  logic      wr_ena;
  reg_addr_t wr_addr;
  word_t     wr_data;
  word_t     busy;
  logic      ld_err;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_data,
    output ld_issue_ready, ld_ready, wr_ena, wr_addr, wr_data, busy, ld_err
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_data,
    input  ld_issue_ready, ld_ready, wr_ena, wr_addr, wr_data, busy, ld_err
  );
endinterface

// File: rtl/regfile_writeback_tag_fifo.sv
// Destination-tag FIFO for outstanding loads.
//   clk, rst    : clock / synchronous reset
//   i_push      : push i_push_tag (ignored when full)
//   i_pop       : drop the head entry (ignored when empty)
//   o_head      : oldest outstanding tag
//   o_full      : DEPTH entries held
//   o_empty     : no entries held
//   o_entries   : all slots flattened, slot k at [k*5 +: 5]
//   o_valid     : per-slot occupancy, for the busy reduction
module wb_tag_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_push,
  input  reg_addr_t                            i_push_tag,
  input  logic                                 i_pop,
  output reg_addr_t                            o_head,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic [DEPTH*$bits(reg_addr_t)-1:0]   o_entries,
  output logic [DEPTH-1:0]                     o_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $bits(reg_addr_t);

  reg_addr_t       r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_tag;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  // A slot is live when its distance from the read pointer (mod DEPTH)
  // is below the occupancy count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PW-1:0] w_off;
    assign w_off                   = PW'(gi) - r_rd_ptr;
    assign o_valid[gi]             = ({1'b0, w_off} < r_count);
    assign o_entries[gi*TW +: TW]  = r_mem[gi];
  end
endmodule

// File: rtl/register.sv
// Generic enabled register with synchronous active-high reset.
//   clk, rst : clock / synchronous reset
//   i_en     : load enable
//   i_d      : next value
//   o_q      : registered value (RESET_VALUE after reset)
module register #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_VALUE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/regfile_writeback.sv
// Writeback controller driving the register file's single write port.
// Merges ALU results (highest priority) and in-order load responses into one
// registered write per cycle; a one-entry hold slot absorbs a load response
// that collides with an ALU write. Tracks outstanding load destinations and
// exports a busy scoreboard.
//   clk, rst : clock / synchronous active-high reset
//   bus      : slave side of regfile_writeback_if (ALU, load issue/response,
//              register-file write port, busy, ld_err)
module regfile_writeback
  import cpu_pkg::*;
  import regfile_writeback_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_writeback_if.slave   bus
);
  localparam int TW = $bits(reg_addr_t);

  hold_state_t r_state;
  hold_state_t w_state_next;

  reg_addr_t                  w_fifo_head;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [LD_DEPTH*TW-1:0]     w_fifo_entries;
  logic [LD_DEPTH-1:0]        w_fifo_valid;
  reg_addr_t                  w_fifo_tags [LD_DEPTH];

  logic      w_ld_ready;
  logic      w_ld_accept;
  logic      w_issue_ready;
  logic      w_push;
  logic      w_pop;
  logic      w_sel;
  reg_addr_t w_sel_addr;
  word_t     w_sel_data;
  logic      w_hold_load;
  word_t     w_hold_data;
  logic      w_err_set;
  word_t     w_busy;

  // Load responses are only meaningful while a tag is outstanding.
  assign w_ld_accept   = bus.ld_valid & w_ld_ready & ~w_fifo_empty;
  assign w_err_set     = bus.ld_valid & w_fifo_empty;
  assign w_issue_ready = ~w_fifo_full;
  assign w_push        = bus.ld_issue & w_issue_ready;

  wb_tag_fifo #(.DEPTH(LD_DEPTH)) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_tag (bus.ld_issue_rd),
    .i_pop      (w_pop),
    .o_head     (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_entries  (w_fifo_entries),
    .o_valid    (w_fifo_valid)
  );

  // Hold FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HOLD_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Hold FSM: next state. A FULL slot drains on the first cycle without an
  // ALU write.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HOLD_EMPTY: if (bus.alu_valid & w_ld_accept) w_state_next = HOLD_FULL;
      HOLD_FULL:  if (!bus.alu_valid)              w_state_next = HOLD_EMPTY;
      default:    w_state_next = HOLD_EMPTY;
    endcase
  end

  // Hold FSM: outputs
  always_comb begin
    w_ld_ready = (r_state == HOLD_EMPTY);
  end

  // Write-source selection: ALU, then held load data, then a live response.
  always_comb begin
    w_sel       = 1'b0;
    w_sel_addr  = REG_ZERO;
    w_sel_data  = '0;
    w_pop       = 1'b0;
    w_hold_load = 1'b0;
    if (bus.alu_valid) begin
      w_sel       = 1'b1;
      w_sel_addr  = bus.alu_rd;
      w_sel_data  = bus.alu_data;
      w_hold_load = w_ld_accept;
    end else if (r_state == HOLD_FULL) begin
      w_sel      = 1'b1;
      w_sel_addr = w_fifo_head;
      w_sel_data = w_hold_data;
      w_pop      = 1'b1;
    end else if (w_ld_accept) begin
      w_sel      = 1'b1;
      w_sel_addr = w_fifo_head;
      w_sel_data = bus.ld_data;
      w_pop      = 1'b1;
    end
  end

  register #(.WIDTH(32)) u_hold (
    .clk(clk), .rst(rst), .i_en(w_hold_load), .i_d(bus.ld_data), .o_q(w_hold_data)
  );

  // x0 writes are still selected (and pop their tag) but never enable the port.
  register #(.WIDTH(1)) u_wr_ena (
    .clk(clk), .rst(rst), .i_en(1'b1),
    .i_d(w_sel & (w_sel_addr != REG_ZERO)), .o_q(bus.wr_ena)
  );

  register #(.WIDTH(TW)) u_wr_addr (
    .clk(clk), .rst(rst), .i_en(w_sel), .i_d(w_sel_addr), .o_q(bus.wr_addr)
  );

  register #(.WIDTH(32)) u_wr_data (
    .clk(clk), .rst(rst), .i_en(w_sel), .i_d(w_sel_data), .o_q(bus.wr_data)
  );

  register #(.WIDTH(1)) u_ld_err (
    .clk(clk), .rst(rst), .i_en(w_err_set), .i_d(1'b1), .o_q(bus.ld_err)
  );

  // Busy scoreboard: OR of one-hot decodes of every live tag; x0 never busy.
  for (genvar gi = 0; gi < LD_DEPTH; gi++) begin : g_tag
    assign w_fifo_tags[gi] = w_fifo_entries[gi*TW +: TW];
  end

  always_comb begin
    w_busy = '0;
    for (int j = 0; j < LD_DEPTH; j++) begin
      if (w_fifo_valid[j]) w_busy = w_busy | tag_onehot(w_fifo_tags[j]);
    end
    w_busy[0] = 1'b0;
  end

  assign bus.busy           = w_busy;
  assign bus.ld_ready       = w_ld_ready;
  assign bus.ld_issue_ready = w_issue_ready;
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  localparam int LD_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_writeback_if bus();

  regfile_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [4:0]  m_q[$];      // outstanding load destinations, oldest first
  bit          m_hold_full;
  logic [31:0] m_hold;
  bit          m_wr_ena;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_started = 0;

  always @(posedge clk) begin
    bit          acc, sel, pop, can_push;
    logic [4:0]  a;
    logic [31:0] d;
    m_started = 1;
    if (rst) begin
      m_q.delete();
      m_hold_full = 0;
      m_wr_ena = 0;
      m_addr = '0;
      m_data = '0;
      m_err = 0;
    end else begin
      acc = bus.ld_valid && !m_hold_full && (m_q.size() > 0);
      if (bus.ld_valid && m_q.size() == 0) m_err = 1;
      can_push = bus.ld_issue && (m_q.size() < LD_DEPTH);
      sel = 0; pop = 0; a = '0; d = '0;
      if (bus.alu_valid) begin
        sel = 1; a = bus.alu_rd; d = bus.alu_data;
        if (acc) begin
          m_hold_full = 1;
          m_hold = bus.ld_data;
        end
      end else if (m_hold_full) begin
        sel = 1; a = m_q[0]; d = m_hold; pop = 1;
        m_hold_full = 0;
      end else if (acc) begin
        sel = 1; a = m_q[0]; d = bus.ld_data; pop = 1;
      end
      if (pop) void'(m_q.pop_front());
      if (can_push) m_q.push_back(bus.ld_issue_rd);
      m_wr_ena = sel && (a != 5'd0);
      if (sel) begin
        m_addr = a;
        m_data = d;
      end
    end
  end

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (m_q[k]) b[m_q[k]] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_started) begin
      check("wr_ena", {31'd0, bus.wr_ena}, {31'd0, m_wr_ena});
      if (m_wr_ena) begin
        check("wr_addr", {27'd0, bus.wr_addr}, {27'd0, m_addr});
        check("wr_data", bus.wr_data, m_data);
      end
      check("busy", bus.busy, model_busy());
      check("ld_ready", {31'd0, bus.ld_ready}, {31'd0, !m_hold_full});
      check("ld_issue_ready", {31'd0, bus.ld_issue_ready}, {31'd0, m_q.size() < LD_DEPTH});
      check("ld_err", {31'd0, bus.ld_err}, {31'd0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.ld_issue = 0; bus.ld_valid = 0;
  endtask

  initial begin
    idle();
    bus.alu_rd = '0; bus.alu_data = '0; bus.ld_issue_rd = '0; bus.ld_data = '0;
    rst = 1;
    cyc(); cyc();
    rst = 0;
    check("rst_wr_ena", {31'd0, bus.wr_ena}, 32'd0);
    check("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
    check("rst_wr_data", bus.wr_data, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_issue_ready", {31'd0, bus.ld_issue_ready}, 32'd1);
    check("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    check("rst_ld_err", {31'd0, bus.ld_err}, 32'd0);

    // ALU write
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    cyc(); idle();
    check("alu_wr_ena", {31'd0, bus.wr_ena}, 32'd1);
    check("alu_wr_addr", {27'd0, bus.wr_addr}, 32'd5);
    check("alu_wr_data", bus.wr_data, 32'hDEADBEEF);
    cyc();
    check("alu_wr_ena_off", {31'd0, bus.wr_ena}, 32'd0);

    // x0 suppression, ALU and load
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFFFFFF;
    cyc(); idle();
    check("x0_alu_wr_ena", {31'd0, bus.wr_ena}, 32'd0);
    bus.ld_issue = 1; bus.ld_issue_rd = 0;
    cyc(); idle();
    check("x0_ld_busy", bus.busy, 32'd0);
    bus.ld_valid = 1; bus.ld_data = 32'h55555555;
    cyc(); idle();
    check("x0_ld_wr_ena", {31'd0, bus.wr_ena}, 32'd0);
    check("x0_ld_busy2", bus.busy, 32'd0);

    // Load path
    bus.ld_issue = 1; bus.ld_issue_rd = 7;
    cyc(); idle();
    check("ld_busy7", bus.busy, 32'h0000_0080);
    bus.ld_valid = 1; bus.ld_data = 32'h00001234;
    cyc(); idle();
    check("ld_wr_ena", {31'd0, bus.wr_ena}, 32'd1);
    check("ld_wr_addr", {27'd0, bus.wr_addr}, 32'd7);
    check("ld_wr_data", bus.wr_data, 32'h00001234);
    check("ld_busy_clr", bus.busy, 32'd0);

    // Collision
    bus.ld_issue = 1; bus.ld_issue_rd = 3;
    cyc(); idle();
    bus.alu_valid = 1; bus.alu_rd = 9; bus.alu_data = 32'hA;
    bus.ld_valid = 1; bus.ld_data = 32'hB;
    cyc(); idle();
    check("col_alu_addr", {27'd0, bus.wr_addr}, 32'd9);
    check("col_alu_data", bus.wr_data, 32'hA);
    check("col_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    check("col_busy3", bus.busy, 32'h0000_0008);
    cyc();
    check("col_ld_ena", {31'd0, bus.wr_ena}, 32'd1);
    check("col_ld_addr", {27'd0, bus.wr_addr}, 32'd3);
    check("col_ld_data", bus.wr_data, 32'hB);
    check("col_ld_ready2", {31'd0, bus.ld_ready}, 32'd1);
    check("col_busy_clr", bus.busy, 32'd0);

    // FIFO full
    for (int k = 0; k < 4; k++) begin
      bus.ld_issue = 1; bus.ld_issue_rd = 5'(10 + k);
      cyc();
    end
    idle();
    check("full_issue_ready", {31'd0, bus.ld_issue_ready}, 32'd0);
    bus.ld_issue = 1; bus.ld_issue_rd = 14;
    cyc(); idle();
    check("full_busy", bus.busy, 32'h0000_3C00);
    for (int k = 0; k < 4; k++) begin
      bus.ld_valid = 1; bus.ld_data = 32'(100 + k);
      cyc();
      check("full_rsp_addr", {27'd0, bus.wr_addr}, 32'(10 + k));
      check("full_rsp_data", bus.wr_data, 32'(100 + k));
    end
    idle();
    check("full_drained_ready", {31'd0, bus.ld_issue_ready}, 32'd1);

    // Error on empty FIFO
    bus.ld_valid = 1; bus.ld_data = 32'h77;
    cyc(); idle();
    check("err_set", {31'd0, bus.ld_err}, 32'd1);
    check("err_no_write", {31'd0, bus.wr_ena}, 32'd0);

    // Reset with hold FULL
    bus.ld_issue = 1; bus.ld_issue_rd = 4;
    cyc(); idle();
    bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_data = 32'h66;
    bus.ld_valid = 1; bus.ld_data = 32'h44;
    cyc(); idle();
    check("pre_rst_hold_full", {31'd0, bus.ld_ready}, 32'd0);
    rst = 1;
    cyc();
    rst = 0;
    check("mid_rst_wr_ena", {31'd0, bus.wr_ena}, 32'd0);
    check("mid_rst_busy", bus.busy, 32'd0);
    check("mid_rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    check("mid_rst_ld_err", {31'd0, bus.ld_err}, 32'd0);
    cyc();
    check("post_rst_wr_ena", {31'd0, bus.wr_ena}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(199) == 0);
      bus.alu_valid  = ($urandom_range(99) < 35);
      bus.alu_rd     = 5'($urandom);
      bus.alu_data   = $urandom;
      bus.ld_issue   = ($urandom_range(99) < 40);
      bus.ld_issue_rd = 5'($urandom);
      bus.ld_valid   = (m_q.size() > 0) ? ($urandom_range(99) < 50) : ($urandom_range(99) < 2);
      bus.ld_data    = $urandom;
      cyc();
    end
    rst = 0;
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
